// File: rtl/hdmi_fetch_pkg.sv
// Shared types and defaults for the HDMI scan-out line fetch scheduler.
package hdmi_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_X_SIZE      = 1600;
  localparam int unsigned DEF_Y_SIZE      = 900;
  localparam int unsigned DEF_BURST_WORDS = 64;

  // Words for the next command: a full burst, or whatever is left of the line.
  function automatic logic [31:0] min_chunk(input logic [31:0] burst_words,
                                            input logic [31:0] remaining);
    return (remaining < burst_words) ? remaining : burst_words;
  endfunction

endpackage

// File: rtl/hdmi_line_fetch_sched_if.sv
// Read-command channel between the line fetch scheduler and the DRAM read engine.
interface hdmi_line_fetch_sched_if;
  // kick is valid, busy is ready: a command transfers on any cycle with both
  // high. While kick waits for busy, read_addr/read_num stay stable; only a
  // frame_start may withdraw a pending kick.
  logic        kick;
  logic        busy;
  logic [31:0] read_addr;
  logic [31:0] read_num;

  modport master (output kick, read_addr, read_num, input busy);
  modport slave  (input kick, read_addr, read_num, output busy);
endinterface

// File: rtl/hdmi_fifo_credit.sv
// Pixel FIFO occupancy tracker: counts words issued minus words popped and flags pops from empty.
module hdmi_fifo_credit #(
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          add_i,
  input  logic [LW-1:0] add_num_i,
  input  logic          pop_i,
  output logic [LW-1:0] free_o,
  output logic          underrun_o
);

  logic [LW-1:0] level_q, level_d;
  logic          underrun_q, underrun_d;

  always_comb begin
    level_d    = level_q;
    underrun_d = 1'b0;
    if (clear_i) begin
      level_d = '0;
    end else if (add_i) begin
      // A pop alongside an add never underflows: add_num is at least one.
      level_d = level_q + add_num_i - LW'(pop_i);
    end else if (pop_i) begin
      if (level_q == '0) underrun_d = 1'b1;
      else               level_d    = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end

  assign free_o     = LW'(FIFO_DEPTH) - level_q;
  assign underrun_o = underrun_q;

endmodule

// File: rtl/hdmi_line_fetch_sched.sv
// DRAM read scheduler for HDMI scan-out: chunked line fetch, FIFO credit gating, double-buffer swap.
// Optional HDMI_FETCH_STATS_EN adds underrun_cnt_o and lines_fetched_o.
module hdmi_line_fetch_sched
  import hdmi_fetch_pkg::*;
#(
  parameter int unsigned X_SIZE      = DEF_X_SIZE,
  parameter int unsigned Y_SIZE      = DEF_Y_SIZE,
  parameter int unsigned BURST_WORDS = DEF_BURST_WORDS,
  parameter int unsigned FIFO_DEPTH  = 2048,
  parameter int unsigned LINE_STRIDE = 6400
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             frame_start_i,
  input  logic                             line_prefetch_i,
  input  logic                             pix_pop_i,
  input  logic [31:0]                      fb_base_a_i,
  input  logic [31:0]                      fb_base_b_i,
  input  logic                             fb_swap_req_i,
  hdmi_line_fetch_sched_if.master          cmd_if,
  output logic                             fb_sel_o,
  output logic                             underrun_o,
  output logic                             frame_done_o,
  output fetch_state_e                     dbg_state_o
`ifdef HDMI_FETCH_STATS_EN
  ,
  output logic [15:0]                      underrun_cnt_o,
  output logic [11:0]                      lines_fetched_o
`endif
);

  localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OFFW  = $clog2(X_SIZE + 1);
  localparam int unsigned LINEW = $clog2(Y_SIZE + 1);

  fetch_state_e     state_q, state_d;
  logic [LINEW-1:0] line_q, line_d;
  logic [LINEW-1:0] pend_q, pend_d;
  logic [OFFW-1:0]  word_off_q, word_off_d;
  logic             swap_pend_q, swap_pend_d;
  logic             fb_sel_q, fb_sel_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      num_q, num_d;
  logic             frame_done_q, frame_done_d;

  logic [31:0]   chunk;
  logic [31:0]   base;
  logic [31:0]   addr_calc;
  logic          accept;
  logic          line_done;
  logic          pf_inc;
  logic [LW-1:0] free;
  logic          underrun;

  assign chunk     = min_chunk(BURST_WORDS, X_SIZE - 32'(word_off_q));
  assign base      = fb_sel_q ? fb_base_b_i : fb_base_a_i;
  assign addr_calc = base + 32'(line_q) * LINE_STRIDE + (32'(word_off_q) << 2);
  assign accept    = (state_q == ST_ISSUE) && cmd_if.busy;
  assign line_done = (32'(word_off_q) + num_q) == X_SIZE;
  // Prefetches beyond the last line of the frame are dropped.
  assign pf_inc    = line_prefetch_i && ((32'(line_q) + 32'(pend_q)) < Y_SIZE);

  hdmi_fifo_credit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LW         (LW)
  ) u_credit (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (frame_start_i),
    .add_i      (accept),
    .add_num_i  (num_q[LW-1:0]),
    .pop_i      (pix_pop_i),
    .free_o     (free),
    .underrun_o (underrun)
  );

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    pend_d       = pend_q;
    word_off_d   = word_off_q;
    swap_pend_d  = swap_pend_q;
    fb_sel_d     = fb_sel_q;
    addr_d       = addr_q;
    num_d        = num_q;
    frame_done_d = 1'b0;
    if (frame_start_i) begin
      // Restart beats everything, including an in-flight command.
      state_d     = ST_ARM;
      line_d      = '0;
      word_off_d  = '0;
      pend_d      = LINEW'(1);
      fb_sel_d    = fb_sel_q ^ swap_pend_q;
      swap_pend_d = fb_swap_req_i;
    end else begin
      if (fb_swap_req_i) swap_pend_d = 1'b1;
      pend_d = pend_q + LINEW'(pf_inc) - LINEW'(accept && line_done);
      case (state_q)
        ST_ARM: begin
          if ((pend_q != '0) && (chunk <= 32'(free))) begin
            state_d = ST_ISSUE;
            addr_d  = addr_calc;
            num_d   = chunk;
          end
        end
        ST_ISSUE: begin
          if (cmd_if.busy) begin
            if (line_done) begin
              word_off_d = '0;
              line_d     = line_q + LINEW'(1);
              if ((32'(line_q) + 32'd1) == Y_SIZE) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
              end else begin
                state_d = ST_ARM;
              end
            end else begin
              word_off_d = OFFW'(32'(word_off_q) + num_q);
              state_d    = ST_ARM;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      pend_q       <= '0;
      word_off_q   <= '0;
      swap_pend_q  <= 1'b0;
      fb_sel_q     <= 1'b0;
      addr_q       <= '0;
      num_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      pend_q       <= pend_d;
      word_off_q   <= word_off_d;
      swap_pend_q  <= swap_pend_d;
      fb_sel_q     <= fb_sel_d;
      addr_q       <= addr_d;
      num_q        <= num_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cmd_if.kick      = (state_q == ST_ISSUE);
  assign cmd_if.read_addr = addr_q;
  assign cmd_if.read_num  = num_q;
  assign fb_sel_o         = fb_sel_q;
  assign underrun_o       = underrun;
  assign frame_done_o     = frame_done_q;
  assign dbg_state_o      = state_q;

`ifdef HDMI_FETCH_STATS_EN
  logic [15:0] underrun_cnt_q;
  logic [11:0] lines_fetched_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_cnt_q  <= '0;
      lines_fetched_q <= '0;
    end else begin
      if (underrun && (underrun_cnt_q != 16'hFFFF))
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      if (frame_start_i)
        lines_fetched_q <= '0;
      else if (accept && line_done)
        lines_fetched_q <= lines_fetched_q + 12'd1;
    end
  end

  assign underrun_cnt_o  = underrun_cnt_q;
  assign lines_fetched_o = lines_fetched_q;
`endif

endmodule
